rob_multi: RTL and testbench
============================

Name: rob_multi

Overview:
- Parametrised reorder buffer for the out-of-order RV32I core; the next generation of the single-commit ROB.
- Allocates entries in program order from Issue and captures results from NCDB result buses.
- Retires up to COMMIT_W entries per cycle to REG/LSB.
- Adds what the previous ROB lacked: squash-on-mispredict with a redirect PC, an occupancy count, and CDB-bypassed operand lookup.

Parameters:
- DEPTH_LOG, 4, log2 of entry count (DEPTH = 2**DEPTH_LOG)
- XLEN, 32, value width
- NCDB, 2, number of result-bus channels
- COMMIT_W, 2, retire width; legal values 1 or 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- rdy  in  1  global enable; low freezes state
- is_valid  in  1  allocate one entry this cycle
- is_ready  in  1  entry already complete (LUI/AUIPC/JAL)
- is_type  in  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP
- is_dest  in  5  destination register (STORE: LSB slot index)
- is_value  in  XLEN  value if is_ready
- is_pred_taken  in  1  predictor decision (BRANCH)
- is_alt_pc  in  XLEN  PC to redirect to if prediction wrong
- is_tag  out  DEPTH_LOG  tag assigned to the allocating entry (= tail)
- is_full  out  1  no free entry
- rob_count  out  DEPTH_LOG+1  occupied entries
- cdb_valid  in  NCDB  per-channel valid
- cdb_tag  in  NCDB*DEPTH_LOG  per-channel tag, channel k at [k*DEPTH_LOG +: DEPTH_LOG]
- cdb_value  in  NCDB*XLEN  per-channel result
- cdb_taken  in  NCDB  resolved branch direction
- q1_tag, q2_tag  in  DEPTH_LOG  operand lookup tags
- q1_ready, q2_ready  out  1  operand available
- q1_value, q2_value  out  XLEN  operand value
- cm_valid  out  COMMIT_W  per-slot commit strobe, registered
- cm_type  out  COMMIT_W*3  committed type
- cm_dest  out  COMMIT_W*5  committed dest
- cm_value  out  COMMIT_W*XLEN  committed value
- cm_tag  out  COMMIT_W*DEPTH_LOG  committed tag (REG rename clear)
- flush  out  1  one-cycle squash pulse, registered
- flush_pc  out  XLEN  redirect target, valid with flush

Behaviour:
- Reset (rst low, async): head = tail = count = 0; all busy/ready bits 0; every output 0.
- rdy low: no state change; cm_valid and flush forced to 0 on the next edge.
- Per-entry state: busy, ready, type, dest, value, pred_taken, taken, alt_pc.
- is_full = (count == DEPTH); combinational from count. Issue is accepted only when is_valid && !is_full.
  - Full and a commit in the same cycle still blocks issue (conservative).
- Issue writes the tail entry; tail wraps modulo DEPTH.
- CDB channel k with a valid tag whose entry is busy: set ready, write value and taken.
  - Tag of a non-busy entry: ignored.
  - Two channels on the same tag: higher k wins.
- Lookup is combinational:
  - A matching valid CDB channel this cycle returns ready = 1 with the CDB value.
  - Otherwise returns the stored ready/value.
  - A non-busy tag returns ready = 0.
- Slot 0 commits when the head entry is busy and ready.
- Slot 1 (COMMIT_W = 2) commits head+1 when all of the following hold:
  - slot 0 commits;
  - head+1 is busy and ready;
  - head is not BRANCH;
  - head+1 is not BRANCH;
  - not both STORE.
  - Branches therefore always retire alone in slot 0.
- A committed entry clears busy/ready; head advances by the commit count.
- count(next) = count + accepted_issue − commits.
- Commit outputs are registered: the decision in cycle t drives cm_* during t+1 for exactly one cycle.
- Mispredict: slot-0 BRANCH commit with taken != pred_taken.
  - The branch itself commits (cm_valid[0] = 1).
  - flush = 1 and flush_pc = that entry's alt_pc in t+1.
  - At the t edge: head = tail = count = 0 and all busy bits cleared.
  - Issue and CDB writes in cycle t are dropped.
- JUMP/ALU/LOAD/STORE never flush.
- Pointer wrap: head/tail are DEPTH_LOG bits and roll over naturally; full vs. empty is decided by count, never by pointer compare.

Test Plan:
- Reset then issue 3 ALU entries (is_ready = 0) -> is_tag 0,1,2; rob_count = 3; no cm_valid.
- CDB0 tag 1 val 0x55 and CDB1 tag 0 val 0x44 in the same cycle, q1_tag = 1 -> q1_ready = 1, q1_value = 0x55 that cycle; next cycle cm_valid = 2'b11, cm_tag {1,0}, cm_value {0x55,0x44}.
- Fill DEPTH = 16 entries -> is_full = 1, rob_count = 16; a 17th is_valid is ignored; retire all; tail/head wrap to 0; issuing 1 more gives is_tag = 0.
- BRANCH pred_taken = 1, alt_pc = 0x1000, 4 younger entries; CDB taken = 0 -> commit cycle+1: cm_valid = 2'b01, flush = 1, flush_pc = 0x1000; next cycle rob_count = 0, flush = 0.
- Two ready STOREs at head/head+1 -> two consecutive cycles with cm_valid = 2'b01; STORE followed by a ready ALU -> cm_valid = 2'b11.
- rdy held low 3 cycles with the head ready -> cm_valid = 0 and rob_count unchanged; rdy high -> commit occurs. Asserting rst mid-stream clears outputs immediately.

Source files
------------

// File: rtl/rob_multi.sv
// ============================================================================
// rob_multi : multi-commit reorder buffer with squash, occupancy count and
//             CDB-bypassed operand lookup.   Rev 1.0
// ============================================================================
`default_nettype none

module rob_multi #(
  parameter int DEPTH_LOG = 4,
  parameter int XLEN      = 32,
  parameter int NCDB      = 2,
  parameter int COMMIT_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          is_valid,
  input  logic                          is_ready,
  input  logic [2:0]                    is_type,
  input  logic [4:0]                    is_dest,
  input  logic [XLEN-1:0]               is_value,
  input  logic                          is_pred_taken,
  input  logic [XLEN-1:0]               is_alt_pc,
  output logic [DEPTH_LOG-1:0]          is_tag,
  output logic                          is_full,
  output logic [DEPTH_LOG:0]            rob_count,
  input  logic [NCDB-1:0]               cdb_valid,
  input  logic [NCDB*DEPTH_LOG-1:0]     cdb_tag,
  input  logic [NCDB*XLEN-1:0]          cdb_value,
  input  logic [NCDB-1:0]               cdb_taken,
  input  logic [DEPTH_LOG-1:0]          q1_tag,
  input  logic [DEPTH_LOG-1:0]          q2_tag,
  output logic                          q1_ready,
  output logic                          q2_ready,
  output logic [XLEN-1:0]               q1_value,
  output logic [XLEN-1:0]               q2_value,
  output logic [COMMIT_W-1:0]           cm_valid,
  output logic [COMMIT_W*3-1:0]         cm_type,
  output logic [COMMIT_W*5-1:0]         cm_dest,
  output logic [COMMIT_W*XLEN-1:0]      cm_value,
  output logic [COMMIT_W*DEPTH_LOG-1:0] cm_tag,
  output logic                          flush,
  output logic [XLEN-1:0]               flush_pc
);

  localparam int                   DEPTH      = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   c_FULL     = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [2:0]           c_T_STORE  = 3'd2;
  localparam logic [2:0]           c_T_BRANCH = 3'd3;

  logic [DEPTH-1:0]           r_busy;
  logic [DEPTH-1:0]           r_ready;
  logic [DEPTH-1:0]           r_pred;
  logic [DEPTH-1:0]           r_taken;
  logic [2:0]                 r_type   [DEPTH];
  logic [4:0]                 r_dest   [DEPTH];
  logic [XLEN-1:0]            r_value  [DEPTH];
  logic [XLEN-1:0]            r_alt_pc [DEPTH];
  logic [DEPTH_LOG-1:0]       r_head;
  logic [DEPTH_LOG-1:0]       r_tail;
  logic [DEPTH_LOG:0]         r_count;

  logic [COMMIT_W-1:0]        r_cm_valid;
  logic [COMMIT_W*3-1:0]      r_cm_type;
  logic [COMMIT_W*5-1:0]      r_cm_dest;
  logic [COMMIT_W*XLEN-1:0]   r_cm_value;
  logic [COMMIT_W*DEPTH_LOG-1:0] r_cm_tag;
  logic                       r_flush;
  logic [XLEN-1:0]            r_flush_pc;

  logic [DEPTH-1:0]           w_hit;
  logic [DEPTH-1:0]           w_eready;
  logic [DEPTH-1:0]           w_etaken;
  logic [XLEN-1:0]            w_evalue [DEPTH];
  logic [DEPTH_LOG-1:0]       w_h1;
  logic [DEPTH_LOG-1:0]       w_sidx   [2];
  logic                       w_full;
  logic                       w_accept;
  logic                       w_c0;
  logic                       w_c1;
  logic                       w_mispred;
  logic [1:0]                 w_cv;
  logic [DEPTH_LOG:0]         w_ncommit;

  // Per-entry view with this cycle's CDB results merged in; higher channel wins.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i]    = 1'b0;
      w_evalue[i] = r_value[i];
      w_etaken[i] = r_taken[i];
      for (int k = 0; k < NCDB; k++) begin
        if (cdb_valid[k] && (cdb_tag[k*DEPTH_LOG +: DEPTH_LOG] == DEPTH_LOG'(i))) begin
          w_hit[i]    = 1'b1;
          w_evalue[i] = cdb_value[k*XLEN +: XLEN];
          w_etaken[i] = cdb_taken[k];
        end
      end
      w_eready[i] = r_busy[i] & (r_ready[i] | w_hit[i]);
    end
  end

  assign q1_ready = w_eready[q1_tag];
  assign q2_ready = w_eready[q2_tag];
  assign q1_value = r_busy[q1_tag] ? w_evalue[q1_tag] : '0;
  assign q2_value = r_busy[q2_tag] ? w_evalue[q2_tag] : '0;

  assign w_full   = (r_count == c_FULL);
  assign w_accept = is_valid && !w_full;
  assign w_h1     = r_head + DEPTH_LOG'(1);
  assign w_sidx[0] = r_head;
  assign w_sidx[1] = w_h1;

  // Branches retire alone so a squash never discards a younger commit.
  assign w_c0 = w_eready[r_head];
  assign w_c1 = (COMMIT_W == 2) && w_c0 && w_eready[w_h1]
              && (r_type[r_head] != c_T_BRANCH) && (r_type[w_h1] != c_T_BRANCH)
              && !((r_type[r_head] == c_T_STORE) && (r_type[w_h1] == c_T_STORE));
  assign w_mispred = w_c0 && (r_type[r_head] == c_T_BRANCH)
                   && (w_etaken[r_head] != r_pred[r_head]);
  assign w_cv      = {w_c1, w_c0};
  assign w_ncommit = (DEPTH_LOG+1)'(w_c0) + (DEPTH_LOG+1)'(w_c1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_ready <= '0;
      r_pred  <= '0;
      r_taken <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_type[i]   <= '0;
        r_dest[i]   <= '0;
        r_value[i]  <= '0;
        r_alt_pc[i] <= '0;
      end
    end else if (rdy) begin
      if (w_mispred) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_busy  <= '0;
        r_ready <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_busy[i] && w_hit[i]) begin
            r_ready[i] <= 1'b1;
            r_value[i] <= w_evalue[i];
            r_taken[i] <= w_etaken[i];
          end
        end
        if (w_c0) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
        end
        if (w_c1) begin
          r_busy[w_h1]  <= 1'b0;
          r_ready[w_h1] <= 1'b0;
        end
        if (w_accept) begin
          r_busy[r_tail]   <= 1'b1;
          r_ready[r_tail]  <= is_ready;
          r_type[r_tail]   <= is_type;
          r_dest[r_tail]   <= is_dest;
          r_value[r_tail]  <= is_value;
          r_pred[r_tail]   <= is_pred_taken;
          r_taken[r_tail]  <= 1'b0;
          r_alt_pc[r_tail] <= is_alt_pc;
          r_tail           <= r_tail + DEPTH_LOG'(1);
        end
        r_head  <= r_head + DEPTH_LOG'(w_ncommit);
        r_count <= r_count + (DEPTH_LOG+1)'(w_accept) - w_ncommit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cm_valid <= '0;
      r_cm_type  <= '0;
      r_cm_dest  <= '0;
      r_cm_value <= '0;
      r_cm_tag   <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
    end else if (rdy) begin
      r_flush <= w_mispred;
      if (w_mispred) begin
        r_flush_pc <= r_alt_pc[r_head];
      end
      for (int s = 0; s < COMMIT_W; s++) begin
        r_cm_valid[s]                     <= w_cv[s];
        r_cm_type[s*3 +: 3]               <= r_type[w_sidx[s]];
        r_cm_dest[s*5 +: 5]               <= r_dest[w_sidx[s]];
        r_cm_value[s*XLEN +: XLEN]        <= w_evalue[w_sidx[s]];
        r_cm_tag[s*DEPTH_LOG +: DEPTH_LOG] <= w_sidx[s];
      end
    end else begin
      r_cm_valid <= '0;
      r_flush    <= 1'b0;
    end
  end

  assign is_tag    = r_tail;
  assign is_full   = w_full;
  assign rob_count = r_count;
  assign cm_valid  = r_cm_valid;
  assign cm_type   = r_cm_type;
  assign cm_dest   = r_cm_dest;
  assign cm_value  = r_cm_value;
  assign cm_tag    = r_cm_tag;
  assign flush     = r_flush;
  assign flush_pc  = r_flush_pc;

endmodule

`default_nettype wire

// File: tb/tb_rob_multi.sv
// ============================================================================
// tb_rob_multi : vector table, corner-case sequences and a queue-based model
//                driven by random stimulus.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_rob_multi;

  localparam int DL = 4;
  localparam int XL = 32;
  localparam int NC = 2;
  localparam int CW = 2;

  logic        clk, rst, rdy, is_valid, is_ready, is_pred_taken;
  logic [2:0]  is_type;
  logic [4:0]  is_dest;
  logic [31:0] is_value, is_alt_pc;
  logic [3:0]  is_tag;
  logic        is_full;
  logic [4:0]  rob_count;
  logic [1:0]  cdb_valid, cdb_taken;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic [3:0]  q1_tag, q2_tag;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic [1:0]  cm_valid;
  logic [5:0]  cm_type;
  logic [9:0]  cm_dest;
  logic [63:0] cm_value;
  logic [7:0]  cm_tag;
  logic        flush;
  logic [31:0] flush_pc;

  rob_multi #(.DEPTH_LOG(DL), .XLEN(XL), .NCDB(NC), .COMMIT_W(CW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .is_valid(is_valid), .is_ready(is_ready), .is_type(is_type), .is_dest(is_dest),
    .is_value(is_value), .is_pred_taken(is_pred_taken), .is_alt_pc(is_alt_pc),
    .is_tag(is_tag), .is_full(is_full), .rob_count(rob_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .cm_valid(cm_valid), .cm_type(cm_type), .cm_dest(cm_dest), .cm_value(cm_value),
    .cm_tag(cm_tag), .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    rdy = 1'b1; is_valid = 1'b0; is_ready = 1'b0; is_type = 3'd0; is_dest = 5'd0;
    is_value = '0; is_pred_taken = 1'b0; is_alt_pc = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0; cdb_taken = '0;
    q1_tag = '0; q2_tag = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic issue(input logic [2:0] ty, input logic rd, input logic [31:0] val,
                       input logic pred, input logic [31:0] alt);
    is_valid = 1'b1; is_type = ty; is_ready = rd; is_value = val;
    is_pred_taken = pred; is_alt_pc = alt; is_dest = val[4:0];
    step();
    is_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        iv; logic [2:0] ty; logic ird; logic [31:0] ival;
    logic [1:0]  cv; logic [3:0] ct0, ct1; logic [31:0] cval0, cval1;
    logic [3:0]  q1t;
    logic [3:0]  e_tag; logic e_q1r; logic [31:0] e_q1v;
    logic [4:0]  e_cnt; logic [1:0] e_cmv; logic [7:0] e_cmtag; logic [63:0] e_cmval;
  } vec_t;
  vec_t vt [7];

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] tag; logic [2:0] typ; logic [4:0] dest; logic [31:0] value;
    logic ready, pred, taken; logic [31:0] alt;
  } ent_t;
  ent_t        q[$];
  logic [3:0]  m_next;
  logic [1:0]  e_cmv;
  logic [3:0]  e_tag [2];
  logic [31:0] e_val [2];
  logic [2:0]  e_typ [2];
  logic [4:0]  e_dst [2];
  logic        e_fl;
  logic [31:0] e_fpc;

  function automatic ent_t bypass(input ent_t e);
    ent_t r = e;
    for (int k = 0; k < NC; k++) begin
      if (cdb_valid[k] && cdb_tag[k*4 +: 4] == e.tag) begin
        r.ready = 1'b1; r.value = cdb_value[k*32 +: 32]; r.taken = cdb_taken[k];
      end
    end
    return r;
  endfunction

  function automatic logic [32:0] lookup(input logic [3:0] t);
    ent_t e;
    logic [32:0] r = '0;
    foreach (q[i]) begin
      if (q[i].tag == t) begin
        e = bypass(q[i]);
        r = {e.ready, e.ready ? e.value : 32'h0};
      end
    end
    return r;
  endfunction

  task automatic model_cycle();
    ent_t e0, e1, ne;
    logic c0, c1, mis, acc;
    c0 = 1'b0; c1 = 1'b0; mis = 1'b0;
    acc = is_valid && (q.size() < 16);
    if (q.size() > 0) begin
      e0 = bypass(q[0]);
      c0 = e0.ready;
      mis = c0 && (e0.typ == 3'd3) && (e0.taken != e0.pred);
      if (q.size() > 1) begin
        e1 = bypass(q[1]);
        c1 = c0 && e1.ready && e0.typ != 3'd3 && e1.typ != 3'd3 && !(e0.typ == 3'd2 && e1.typ == 3'd2);
      end
    end
    if (!rdy) begin
      e_cmv = 2'b00; e_fl = 1'b0;
      return;
    end
    e_cmv = {c1, c0}; e_fl = mis;
    if (c0) begin
      e_tag[0] = e0.tag; e_val[0] = e0.value; e_typ[0] = e0.typ; e_dst[0] = e0.dest;
    end
    if (c1) begin
      e_tag[1] = e1.tag; e_val[1] = e1.value; e_typ[1] = e1.typ; e_dst[1] = e1.dest;
    end
    if (mis) begin
      e_fpc = q[0].alt;
      q.delete();
      m_next = 4'd0;
      return;
    end
    foreach (q[i]) q[i] = bypass(q[i]);
    if (c0) void'(q.pop_front());
    if (c1) void'(q.pop_front());
    if (acc) begin
      ne.tag = m_next; ne.typ = is_type; ne.dest = is_dest; ne.value = is_value;
      ne.ready = is_ready; ne.pred = is_pred_taken; ne.taken = 1'b0; ne.alt = is_alt_pc;
      q.push_back(ne);
      m_next = m_next + 4'd1;
    end
  endtask

  logic [7:0]  mt;
  logic [63:0] mv;
  logic [32:0] lk;

  initial begin
    vt[0] = '{1'b1,3'd0,1'b0,32'h0, 2'b00,4'd0,4'd0,32'h0,32'h0, 4'd0, 4'd0,1'b0,32'h0,  5'd1,2'b00,8'h00,64'h0};
    vt[1] = '{1'b1,3'd0,1'b0,32'h0, 2'b00,4'd0,4'd0,32'h0,32'h0, 4'd0, 4'd1,1'b0,32'h0,  5'd2,2'b00,8'h00,64'h0};
    vt[2] = '{1'b1,3'd0,1'b0,32'h0, 2'b00,4'd0,4'd0,32'h0,32'h0, 4'd1, 4'd2,1'b0,32'h0,  5'd3,2'b00,8'h00,64'h0};
    vt[3] = '{1'b0,3'd0,1'b0,32'h0, 2'b11,4'd1,4'd0,32'h55,32'h44, 4'd1, 4'd3,1'b1,32'h55, 5'd1,2'b11,8'h10,64'h00000055_00000044};
    vt[4] = '{1'b0,3'd0,1'b0,32'h0, 2'b00,4'd0,4'd0,32'h0,32'h0, 4'd2, 4'd3,1'b0,32'h0,  5'd1,2'b00,8'h00,64'h0};
    vt[5] = '{1'b1,3'd0,1'b1,32'hAB, 2'b01,4'd2,4'd0,32'h77,32'h0, 4'd2, 4'd3,1'b1,32'h77, 5'd1,2'b01,8'h02,64'h77};
    vt[6] = '{1'b0,3'd0,1'b0,32'h0, 2'b00,4'd0,4'd0,32'h0,32'h0, 4'd3, 4'd4,1'b1,32'hAB, 5'd0,2'b01,8'h03,64'hAB};

    idle(); rst = 1'b0;
    step();
    chk("rst_count", rob_count, 0);   chk("rst_full", is_full, 0);
    chk("rst_tag", is_tag, 0);        chk("rst_cmv", cm_valid, 0);
    chk("rst_flush", flush, 0);       chk("rst_fpc", flush_pc, 0);
    chk("rst_q1r", q1_ready, 0);      chk("rst_q1v", q1_value, 0);
    rst = 1'b1;

    foreach (vt[r]) begin
      is_valid = vt[r].iv; is_type = vt[r].ty; is_ready = vt[r].ird; is_value = vt[r].ival;
      cdb_valid = vt[r].cv; cdb_tag = {vt[r].ct1, vt[r].ct0};
      cdb_value = {vt[r].cval1, vt[r].cval0}; cdb_taken = 2'b00; q1_tag = vt[r].q1t;
      #1;
      chk("vec_tag", is_tag, vt[r].e_tag);
      chk("vec_q1r", q1_ready, vt[r].e_q1r);
      if (vt[r].e_q1r) chk("vec_q1v", q1_value, vt[r].e_q1v);
      step();
      mt = {{4{vt[r].e_cmv[1]}}, {4{vt[r].e_cmv[0]}}};
      mv = {{32{vt[r].e_cmv[1]}}, {32{vt[r].e_cmv[0]}}};
      chk("vec_count", rob_count, vt[r].e_cnt);
      chk("vec_cmv", cm_valid, vt[r].e_cmv);
      chk("vec_cmtag", cm_tag & mt, vt[r].e_cmtag);
      chk("vec_cmval", cm_value & mv, vt[r].e_cmval);
    end

    // fill, overflow attempt, drain, wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      is_valid = 1'b1; is_type = 3'd0; is_ready = 1'b0;
      #1 chk("fill_tag", is_tag, i);
      step();
    end
    chk("fill_full", is_full, 1); chk("fill_count", rob_count, 16);
    is_valid = 1'b1;
    step();
    chk("over_count", rob_count, 16); chk("over_tag", is_tag, 0);
    for (int c = 0; c < 8; c++) begin
      is_valid = (c == 0);
      cdb_valid = 2'b11; cdb_tag = {4'(2*c+1), 4'(2*c)};
      step();
      chk("drain_cmv", cm_valid, 2'b11);
      chk("drain_cmtag", cm_tag, {4'(2*c+1), 4'(2*c)});
      chk("drain_count", rob_count, 14 - 2*c);
    end
    idle();
    is_valid = 1'b1;
    #1 chk("wrap_tag", is_tag, 0);
    step();
    chk("wrap_count", rob_count, 1);

    // branch mispredict squashes younger entries
    do_reset();
    issue(3'd3, 1'b0, 32'h0, 1'b1, 32'h1000);
    for (int i = 0; i < 4; i++) issue(3'd0, 1'b1, 32'h10 + i, 1'b0, 32'h0);
    chk("br_count", rob_count, 5);
    chk("br_nocommit", cm_valid, 0);
    cdb_valid = 2'b01; cdb_tag = 8'h00; cdb_taken = 2'b00; is_valid = 1'b1;
    step();
    idle();
    chk("br_cmv", cm_valid, 2'b01);   chk("br_cmtag", cm_tag[3:0], 0);
    chk("br_flush", flush, 1);        chk("br_fpc", flush_pc, 32'h1000);
    chk("br_count0", rob_count, 0);
    step();
    chk("br_flush_off", flush, 0);    chk("br_cmv_off", cm_valid, 0);
    chk("br_count1", rob_count, 0);   chk("br_tag", is_tag, 0);

    // store pairing rules
    do_reset();
    issue(3'd2, 1'b0, 32'h1, 1'b0, 32'h0);
    issue(3'd2, 1'b0, 32'h2, 1'b0, 32'h0);
    issue(3'd2, 1'b0, 32'h3, 1'b0, 32'h0);
    issue(3'd0, 1'b0, 32'h4, 1'b0, 32'h0);
    cdb_valid = 2'b11; cdb_tag = 8'h10; cdb_value = {32'hB, 32'hA};
    step(); idle();
    chk("st_cmv0", cm_valid, 2'b01); chk("st_tag0", cm_tag[3:0], 0);
    step();
    chk("st_cmv1", cm_valid, 2'b01); chk("st_tag1", cm_tag[3:0], 1);
    cdb_valid = 2'b11; cdb_tag = 8'h32;
    step(); idle();
    chk("st_alu_cmv", cm_valid, 2'b11); chk("st_alu_tag", cm_tag, 8'h32);
    chk("st_alu_type", cm_type, 6'b000_010); chk("st_count", rob_count, 0);

    // rdy freeze
    do_reset();
    issue(3'd0, 1'b1, 32'h99, 1'b0, 32'h0);
    rdy = 1'b0; is_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_cmv", cm_valid, 0); chk("frz_count", rob_count, 1);
    end
    rdy = 1'b1; is_valid = 1'b0;
    step();
    chk("frz_rel_cmv", cm_valid, 2'b01); chk("frz_rel_val", cm_value[31:0], 32'h99);
    chk("frz_rel_count", rob_count, 0);

    // asynchronous reset mid-stream
    do_reset();
    issue(3'd0, 1'b1, 32'h5, 1'b0, 32'h0);
    issue(3'd0, 1'b1, 32'h6, 1'b0, 32'h0);
    chk("ar_pre_cmv", cm_valid, 2'b01);
    #2 rst = 1'b0;
    #1;
    chk("ar_cmv", cm_valid, 0); chk("ar_count", rob_count, 0); chk("ar_tag", is_tag, 0);
    rst = 1'b1;

    // randomized run against the queue model
    do_reset();
    q.delete(); m_next = 4'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy = ($urandom_range(0, 9) != 0);
      is_valid = ($urandom_range(0, 3) != 0);
      is_type = 3'($urandom_range(0, 4));
      is_ready = (is_type != 3'd3) && ($urandom_range(0, 1) == 1);
      is_dest = 5'($urandom); is_value = $urandom;
      is_pred_taken = 1'($urandom); is_alt_pc = $urandom;
      for (int k = 0; k < NC; k++) begin
        cdb_valid[k] = ($urandom_range(0, 2) == 0);
        cdb_tag[k*4 +: 4] = (q.size() > 0 && $urandom_range(0, 4) != 0)
                          ? q[$urandom_range(0, q.size()-1)].tag : 4'($urandom);
        cdb_value[k*32 +: 32] = $urandom;
        cdb_taken[k] = 1'($urandom);
      end
      if ($urandom_range(0, 7) == 0) cdb_tag[7:4] = cdb_tag[3:0];
      q1_tag = 4'($urandom);
      q2_tag = (q.size() > 0) ? q[$urandom_range(0, q.size()-1)].tag : 4'($urandom);
      #1;
      chk("rnd_tag", is_tag, m_next);
      chk("rnd_count", rob_count, q.size());
      chk("rnd_full", is_full, q.size() == 16);
      lk = lookup(q1_tag);
      chk("rnd_q1r", q1_ready, lk[32]);
      if (lk[32]) chk("rnd_q1v", q1_value, lk[31:0]);
      lk = lookup(q2_tag);
      chk("rnd_q2r", q2_ready, lk[32]);
      if (lk[32]) chk("rnd_q2v", q2_value, lk[31:0]);
      model_cycle();
      step();
      chk("rnd_cmv", cm_valid, e_cmv);
      for (int s = 0; s < CW; s++) begin
        if (e_cmv[s]) begin
          chk("rnd_cmtag", cm_tag[s*4 +: 4], e_tag[s]);
          chk("rnd_cmval", cm_value[s*32 +: 32], e_val[s]);
          chk("rnd_cmtype", cm_type[s*3 +: 3], e_typ[s]);
          chk("rnd_cmdest", cm_dest[s*5 +: 5], e_dst[s]);
        end
      end
      chk("rnd_flush", flush, e_fl);
      if (e_fl) chk("rnd_fpc", flush_pc, e_fpc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
